// File: rtl/dsw_ser_rd.sv
// dsw_ser_rd -- serial DIP-switch reader.
//
// Drives an external 74HC165-class parallel-in/serial-out register: pulses
// its load pin, clocks NBIT bits out of it MSB first, inverts them (switch ON
// pulls the line low) and debounces whole scan words across consecutive
// scans before presenting them on dsw_on.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high
//   scan_tp  one-cycle scan start tick; ignored while a scan is running
//   dsw_dat  serial data from the shift register, low = switch ON
//   dsw_sht  shift/load pin, 0 = parallel load, 1 = shift
//   dsw_clk  shift clock, rising edge advances the register
//   dsw_on   debounced switch word, 1 = ON, MSB = first bit shifted out
//   dsw_vld  sticky flag, set on the first debounced load
//   dsw_chg  one-cycle pulse when dsw_on changes
//   dsw_busy high while a scan is in progress
module dsw_ser_rd #(
  parameter int NBIT    = 8,
  parameter int CLK_DIV = 2,
  parameter int DEB_N   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            scan_tp,
  input  logic            dsw_dat,
  output logic            dsw_sht,
  output logic            dsw_clk,
  output logic [NBIT-1:0] dsw_on,
  output logic            dsw_vld,
  output logic            dsw_chg,
  output logic            dsw_busy
);

  localparam int BW = $clog2(NBIT);

  typedef enum logic [2:0] {IDLE, LOAD, SAMP, SCLK, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      div;
  logic [BW-1:0]   bitcnt;
  logic [BW-1:0]   cap_idx;
  logic            div_last;
  logic            bit_last;
  logic            sht_nxt, clk_nxt, busy_nxt;
  logic [NBIT-1:0] shreg;
  logic [NBIT-1:0] prev;
  logic [2:0]      match, match_nxt;
  logic            first;

  // Saturating match counter increment, capped at DEB_N.
  function automatic logic [2:0] sat_inc(input logic [2:0] m);
    if (m >= 3'(DEB_N)) return 3'(DEB_N);
    return m + 3'd1;
  endfunction

  assign div_last = (div == 4'(CLK_DIV - 1));
  assign bit_last = (bitcnt == BW'(NBIT - 1));
  assign cap_idx  = BW'(NBIT - 1) - bitcnt;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (scan_tp) state_nxt = LOAD;
      LOAD: if (div_last) state_nxt = SAMP;
      SAMP: if (div_last) state_nxt = bit_last ? DONE : SCLK;
      SCLK: if (div_last) state_nxt = SAMP;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin levels decoded from the upcoming state so the registered outputs
  // line up exactly with the state they belong to.
  always_comb begin
    sht_nxt  = (state_nxt != LOAD);
    clk_nxt  = (state_nxt == SCLK);
    busy_nxt = (state_nxt != IDLE);
  end

  // State register, phase divider, bit counter and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      bitcnt   <= '0;
      dsw_sht  <= 1'b1;
      dsw_clk  <= 1'b0;
      dsw_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      dsw_sht  <= sht_nxt;
      dsw_clk  <= clk_nxt;
      dsw_busy <= busy_nxt;
      // Divider restarts at every phase change and rests at 0 in IDLE.
      if (state_nxt != state || state == IDLE) div <= '0;
      else                                     div <= div + 4'd1;
      if (state == IDLE)                bitcnt <= '0;
      else if (state == SCLK && div_last) bitcnt <= bitcnt + 1'b1;
    end
  end

  // Serial capture: sample in the last SAMP cycle, when the register output
  // has had the longest time to settle after the previous shift edge.
  always_ff @(posedge clk) begin
    if (state == SAMP && div_last) shreg[cap_idx] <= ~dsw_dat;
  end

  always_comb begin
    match_nxt = sat_inc(match);
    if (first || shreg != prev) match_nxt = 3'd1;
  end

  // Debounce: the word is accepted once DEB_N consecutive scans agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      match   <= '0;
      first   <= 1'b1;
      dsw_on  <= '0;
      dsw_vld <= 1'b0;
      dsw_chg <= 1'b0;
    end else begin
      dsw_chg <= 1'b0;
      if (state == DONE) begin
        match <= match_nxt;
        first <= 1'b0;
        if (match_nxt >= 3'(DEB_N)) begin
          dsw_on  <= shreg;
          dsw_vld <= 1'b1;
          dsw_chg <= (shreg != dsw_on);
        end
      end
    end
  end

  // Previous scan word; its validity is tracked by the first-scan flag.
  always_ff @(posedge clk) begin
    if (state == DONE) prev <= shreg;
  end

endmodule

// File: tb/tb_dsw_ser_rd.sv
// Testbench for dsw_ser_rd: two instances (default parameters and a small
// NBIT=4/CLK_DIV=1/DEB_N=1 build), each fed by a behavioural 74HC165 model.
// Expected words come from a history-based debounce model.
module tb_dsw_ser_rd;

  localparam int DEB_A = 2;
  localparam int DEB_B = 1;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  // Instance A (defaults)
  logic       rst = 1'b1, scan_tp = 1'b0, dsw_dat;
  logic       dsw_sht, dsw_clk, dsw_vld, dsw_chg, dsw_busy;
  logic [7:0] dsw_on;
  // Instance B (small)
  logic       rst_b = 1'b1, scan_tp_b = 1'b0, dsw_dat_b;
  logic       dsw_sht_b, dsw_clk_b, dsw_vld_b, dsw_chg_b, dsw_busy_b;
  logic [3:0] dsw_on_b;

  int checks = 0;
  int failures = 0;

  dsw_ser_rd dut_a (
    .clk(clk), .rst(rst), .scan_tp(scan_tp), .dsw_dat(dsw_dat),
    .dsw_sht(dsw_sht), .dsw_clk(dsw_clk), .dsw_on(dsw_on),
    .dsw_vld(dsw_vld), .dsw_chg(dsw_chg), .dsw_busy(dsw_busy)
  );

  dsw_ser_rd #(.NBIT(4), .CLK_DIV(1), .DEB_N(1)) dut_b (
    .clk(clk), .rst(rst_b), .scan_tp(scan_tp_b), .dsw_dat(dsw_dat_b),
    .dsw_sht(dsw_sht_b), .dsw_clk(dsw_clk_b), .dsw_on(dsw_on_b),
    .dsw_vld(dsw_vld_b), .dsw_chg(dsw_chg_b), .dsw_busy(dsw_busy_b)
  );

  // 74HC165 models: load while sht=0, advance on dsw_clk rising edge.
  logic [7:0] sw_a = 8'h00, latch_a = 8'h00;
  logic [3:0] sw_b = 4'h0, latch_b = 4'h0;
  int cnt_a = 0, cnt_b = 0;
  logic pclk_a = 1'b0, pclk_b = 1'b0;

  always @(negedge clk) begin
    if (!dsw_sht) begin latch_a = sw_a; cnt_a = 0; end
    else if (dsw_clk && !pclk_a) cnt_a++;
    pclk_a = dsw_clk;
    if (!dsw_sht_b) begin latch_b = sw_b; cnt_b = 0; end
    else if (dsw_clk_b && !pclk_b) cnt_b++;
    pclk_b = dsw_clk_b;
  end

  assign dsw_dat   = (cnt_a < 8) ? ~latch_a[7 - cnt_a] : 1'b1;
  assign dsw_dat_b = (cnt_b < 4) ? ~latch_b[3 - cnt_b] : 1'b1;

  // Waveform monitors.
  int shtlo_a = 0, pulses_a = 0, bad_w = 0, hi_run = 0, lo_run = 0;
  int pulses_b = 0;
  logic mp_a = 1'b0, mp_b = 1'b0;

  always @(negedge clk) begin
    if (!dsw_sht) shtlo_a++;
    if (dsw_clk && !mp_a) begin
      if (pulses_a > 0 && lo_run != 2) bad_w++;
      pulses_a++;
      hi_run = 1;
    end else if (dsw_clk) begin
      hi_run++;
    end else if (mp_a) begin
      if (hi_run != 2) bad_w++;
      lo_run = 1;
    end else begin
      lo_run++;
    end
    mp_a = dsw_clk;
    if (dsw_clk_b && !mp_b) pulses_b++;
    mp_b = dsw_clk_b;
  end

  // Debounce reference: the word is accepted when the last DEB scans since
  // reset are all identical.
  logic [7:0] hist_a[$];
  logic [3:0] hist_b[$];
  logic [7:0] exp_on_a = 8'h00;
  logic       exp_vld_a = 1'b0;
  logic [3:0] exp_on_b = 4'h0;
  logic       exp_vld_b = 1'b0;

  task automatic model_a(input logic [7:0] w, output logic exp_chg);
    bit same;
    hist_a.push_back(w);
    exp_chg = 1'b0;
    if (hist_a.size() >= DEB_A) begin
      same = 1'b1;
      for (int i = 1; i < DEB_A; i++)
        if (hist_a[hist_a.size() - 1 - i] != w) same = 1'b0;
      if (same) begin
        exp_chg   = (exp_on_a != w);
        exp_on_a  = w;
        exp_vld_a = 1'b1;
      end
    end
  endtask

  task automatic model_b(input logic [3:0] w, output logic exp_chg);
    bit same;
    hist_b.push_back(w);
    exp_chg = 1'b0;
    if (hist_b.size() >= DEB_B) begin
      same = 1'b1;
      for (int i = 1; i < DEB_B; i++)
        if (hist_b[hist_b.size() - 1 - i] != w) same = 1'b0;
      if (same) begin
        exp_chg   = (exp_on_b != w);
        exp_on_b  = w;
        exp_vld_b = 1'b1;
      end
    end
  endtask

  // Runs one scan on instance A. busy = number of busy cycles (-1 on
  // timeout); sht0 = dsw_sht in the first cycle after scan_tp. Returns in
  // the cycle after DONE. tp_at > 0 fires an extra scan_tp mid-scan.
  task automatic scan_a(input logic [7:0] w, input int tp_at,
                        output int busy, output logic sht0);
    int n;
    sw_a = w; pulses_a = 0; shtlo_a = 0; bad_w = 0; hi_run = 0; lo_run = 0;
    @(posedge clk); #1 scan_tp = 1'b1;
    @(posedge clk); #1 scan_tp = 1'b0;
    sht0 = dsw_sht;
    n = 0;
    while (dsw_busy && n < 200) begin
      n++;
      scan_tp = (n == tp_at);
      @(posedge clk); #1;
    end
    scan_tp = 1'b0;
    busy = dsw_busy ? -1 : n;
  endtask

  task automatic scan_b(input logic [3:0] w, output int busy);
    int n;
    sw_b = w; pulses_b = 0;
    @(posedge clk); #1 scan_tp_b = 1'b1;
    @(posedge clk); #1 scan_tp_b = 1'b0;
    n = 0;
    while (dsw_busy_b && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    busy = dsw_busy_b ? -1 : n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dsw_sht, dsw_clk, dsw_busy, dsw_vld, dsw_chg} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: sht/clk/busy/vld/chg=%b expected 10000",
               {dsw_sht, dsw_clk, dsw_busy, dsw_vld, dsw_chg});
    end
    checks++;
    if (dsw_on !== 8'h00) begin
      failures++;
      $display("FAIL reset_on: got %h expected 00", dsw_on);
    end
    rst = 1'b0;
    hist_a.delete(); exp_on_a = 8'h00; exp_vld_a = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_first_scans();
    int busy; logic sht0, ec;
    scan_a(8'hA5, 0, busy, sht0);
    model_a(8'hA5, ec);
    checks++;
    if (busy !== 33) begin failures++; $display("FAIL busy_len: got %0d expected 33", busy); end
    checks++;
    if (sht0 !== 1'b0 || shtlo_a !== 2) begin
      failures++;
      $display("FAIL load_pulse: first sht=%b low cycles=%0d expected 0/2", sht0, shtlo_a);
    end
    checks++;
    if (pulses_a !== 7 || bad_w !== 0) begin
      failures++;
      $display("FAIL sclk_pulses: pulses=%0d bad widths=%0d expected 7/0", pulses_a, bad_w);
    end
    checks++;
    if (dsw_on !== exp_on_a || dsw_vld !== exp_vld_a || dsw_chg !== ec) begin
      failures++;
      $display("FAIL scan1: on=%h vld=%b chg=%b expected %h/%b/%b",
               dsw_on, dsw_vld, dsw_chg, exp_on_a, exp_vld_a, ec);
    end
    repeat (1000) @(posedge clk);
    scan_a(8'hA5, 0, busy, sht0);
    model_a(8'hA5, ec);
    checks++;
    if (dsw_on !== 8'hA5 || dsw_vld !== 1'b1 || dsw_chg !== 1'b1 || exp_on_a !== 8'hA5) begin
      failures++;
      $display("FAIL scan2: on=%h vld=%b chg=%b expected a5/1/1", dsw_on, dsw_vld, dsw_chg);
    end
    @(posedge clk); #1;
    checks++;
    if (dsw_chg !== 1'b0) begin failures++; $display("FAIL chg_width: got %b expected 0", dsw_chg); end
  endtask

  task automatic test_bounce();
    int busy; logic sht0, ec;
    logic [7:0] words [3];
    words[0] = 8'hA5; words[1] = 8'hA4; words[2] = 8'hA4;
    for (int i = 0; i < 3; i++) begin
      scan_a(words[i], 0, busy, sht0);
      model_a(words[i], ec);
      checks++;
      if (dsw_on !== exp_on_a || dsw_chg !== ec || dsw_vld !== exp_vld_a) begin
        failures++;
        $display("FAIL bounce%0d: on=%h chg=%b vld=%b expected %h/%b/%b",
                 i, dsw_on, dsw_chg, dsw_vld, exp_on_a, ec, exp_vld_a);
      end
    end
  endtask

  task automatic test_ignore_tp();
    int busy; logic sht0, ec;
    scan_a(8'hA5, 10, busy, sht0);
    model_a(8'hA5, ec);
    checks++;
    if (busy !== 33) begin failures++; $display("FAIL ignore_tp_len: got %0d expected 33", busy); end
    @(posedge clk); #1;
    checks++;
    if (dsw_busy !== 1'b0) begin failures++; $display("FAIL ignore_tp_restart: busy=%b expected 0", dsw_busy); end
    for (int i = 0; i < 3; i++) begin
      scan_a(8'hA5, 0, busy, sht0);
      model_a(8'hA5, ec);
      checks++;
      if (dsw_on !== exp_on_a || dsw_chg !== ec) begin
        failures++;
        $display("FAIL stable%0d: on=%h chg=%b expected %h/%b", i, dsw_on, dsw_chg, exp_on_a, ec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int busy, n; logic sht0, ec;
    sw_a = 8'h3C;
    @(posedge clk); #1 scan_tp = 1'b1;
    @(posedge clk); #1 scan_tp = 1'b0;
    n = 0;
    while (!dsw_clk && n < 50) begin n++; @(posedge clk); #1; end
    checks++;
    if (dsw_clk !== 1'b1) begin failures++; $display("FAIL reach_sclk: dsw_clk=%b expected 1", dsw_clk); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({dsw_sht, dsw_clk, dsw_busy, dsw_vld} !== 4'b1000 || dsw_on !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset: sht/clk/busy/vld=%b on=%h expected 1000/00",
               {dsw_sht, dsw_clk, dsw_busy, dsw_vld}, dsw_on);
    end
    rst = 1'b0;
    hist_a.delete(); exp_on_a = 8'h00; exp_vld_a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      scan_a(8'h3C, 0, busy, sht0);
      model_a(8'h3C, ec);
      checks++;
      if (dsw_on !== exp_on_a || dsw_vld !== exp_vld_a || dsw_chg !== ec || busy !== 33) begin
        failures++;
        $display("FAIL after_reset%0d: on=%h vld=%b chg=%b busy=%0d expected %h/%b/%b/33",
                 i, dsw_on, dsw_vld, dsw_chg, busy, exp_on_a, exp_vld_a, ec);
      end
    end
  endtask

  task automatic test_random();
    int busy, reps; logic sht0, ec; logic [7:0] w;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hist_a.delete(); exp_on_a = 8'h00; exp_vld_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      w = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        scan_a(w, 0, busy, sht0);
        model_a(w, ec);
        checks++;
        if (dsw_on !== exp_on_a || dsw_vld !== exp_vld_a || dsw_chg !== ec || busy !== 33) begin
          failures++;
          $display("FAIL rand%0d_%0d: on=%h vld=%b chg=%b busy=%0d expected %h/%b/%b/33",
                   i, r, dsw_on, dsw_vld, dsw_chg, busy, exp_on_a, exp_vld_a, ec);
        end
        repeat ($urandom_range(0, 5)) @(posedge clk);
      end
    end
  endtask

  task automatic test_small();
    int busy; logic ec; logic [3:0] w;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    hist_b.delete(); exp_on_b = 4'h0; exp_vld_b = 1'b0;
    scan_b(4'h9, busy);
    model_b(4'h9, ec);
    checks++;
    if (busy !== 9 || pulses_b !== 3) begin
      failures++;
      $display("FAIL small_wave: busy=%0d pulses=%0d expected 9/3", busy, pulses_b);
    end
    checks++;
    if (dsw_on_b !== 4'h9 || dsw_vld_b !== 1'b1 || dsw_chg_b !== 1'b1 || exp_on_b !== 4'h9) begin
      failures++;
      $display("FAIL small_scan: on=%h vld=%b chg=%b expected 9/1/1", dsw_on_b, dsw_vld_b, dsw_chg_b);
    end
    for (int i = 0; i < 6; i++) begin
      w = 4'($urandom);
      scan_b(w, busy);
      model_b(w, ec);
      checks++;
      if (dsw_on_b !== exp_on_b || dsw_chg_b !== ec || busy !== 9) begin
        failures++;
        $display("FAIL small_rand%0d: on=%h chg=%b busy=%0d expected %h/%b/9",
                 i, dsw_on_b, dsw_chg_b, busy, exp_on_b, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_scans();
    test_bounce();
    test_ignore_tp();
    test_reset_mid();
    test_random();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
